// File: rtl/hp_counter_pkg.sv
// Shared constants and helpers for the player hit-point manager.
package hp_counter_pkg;

  localparam int unsigned HP_W           = 4;
  localparam int unsigned HP_MAX_DEFAULT = 10;
  localparam int unsigned ST_W           = 2;
  // Signed width for heal/damage arithmetic: 15 + 15 and 0 - 15 both fit.
  localparam int unsigned NET_W          = 6;

  localparam logic signed [NET_W-1:0] NET_ZERO = '0;

  typedef enum logic [ST_W-1:0] {
    ST_ALIVE = 2'd0,
    ST_INV   = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  // Clamp a signed net HP value into 0..hp_max.
  function automatic logic [HP_W-1:0] clamp_hp(input logic signed [NET_W-1:0] net,
                                               input logic [HP_W-1:0]         hp_max);
    logic signed [NET_W-1:0] max_s;
    max_s = $signed(NET_W'(hp_max));
    if (net <= NET_ZERO) begin
      clamp_hp = '0;
    end else if (net >= max_s) begin
      clamp_hp = hp_max;
    end else begin
      clamp_hp = net[HP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/hp_timer.sv
// Loadable down-counter shared by the invincibility and respawn windows.
module hp_timer #(
  parameter int unsigned CNT_W = 27
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero_c
);

  assign zero_c = (cnt == '0);

  // Load wins over decrement; the count parks at zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !zero_c) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hp_counter.sv
// Player hit-point manager: saturating damage/heal, post-hit invincibility,
// and a timed death/respawn sequence.
module hp_counter
  import hp_counter_pkg::*;
#(
  parameter int unsigned HP_MAX         = HP_MAX_DEFAULT,
  parameter int unsigned INV_CYCLES     = 50_000_000,
  parameter int unsigned RESPAWN_CYCLES = 100_000_000,
  parameter int unsigned CNT_W          = 27
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            DMG_REQ,
  input  logic [HP_W-1:0] DMG_AMT,
  input  logic            HEAL_REQ,
  input  logic [HP_W-1:0] HEAL_AMT,
  output logic [HP_W-1:0] OUT_HP,
  output logic            INV,
  output logic            DEAD,
  output logic            HIT,
  output logic            RESPAWN
);

  localparam logic [HP_W-1:0]  HP_FULL   = HP_W'(HP_MAX);
  localparam logic [CNT_W-1:0] INV_LOAD  = CNT_W'(INV_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'(RESPAWN_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [HP_W-1:0]         hp_q, hp_d;
  logic                    inv_q, dead_q, hit_q, respawn_q;
  logic                    hit_d, respawn_d;
  logic                    tmr_load_c, tmr_en_c, tmr_zero_c;
  logic [CNT_W-1:0]        tmr_val_c, tmr_cnt;
  logic [HP_W-1:0]         heal_v_c, dmg_v_c;
  logic signed [NET_W-1:0] net_c;

  hp_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .en       (tmr_en_c),
    .cnt      (tmr_cnt),
    .zero_c   (tmr_zero_c)
  );

  assign tmr_en_c = (state_q != ST_ALIVE);

  // Next-state, next-HP and pulse generation.
  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    hit_d      = 1'b0;
    respawn_d  = 1'b0;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    heal_v_c   = HEAL_REQ ? HEAL_AMT : '0;
    dmg_v_c    = DMG_REQ  ? DMG_AMT  : '0;
    net_c      = NET_ZERO;

    case (state_q)
      ST_ALIVE: begin
        net_c = NET_W'(hp_q) + NET_W'(heal_v_c) - NET_W'(dmg_v_c);
        hp_d  = clamp_hp(net_c, HP_FULL);
        if (DMG_REQ && (DMG_AMT != '0)) begin
          hit_d      = 1'b1;
          tmr_load_c = 1'b1;
          if (net_c <= NET_ZERO) begin
            state_d   = ST_DEAD;
            tmr_val_c = RESP_LOAD;
          end else begin
            state_d   = ST_INV;
            tmr_val_c = INV_LOAD;
          end
        end
      end
      ST_INV: begin
        // Damage is ignored while invincible; heal still applies.
        net_c = NET_W'(hp_q) + NET_W'(heal_v_c);
        hp_d  = clamp_hp(net_c, HP_FULL);
        if (tmr_zero_c) begin
          state_d = ST_ALIVE;
        end
      end
      ST_DEAD: begin
        hp_d = '0;
        if (tmr_zero_c) begin
          state_d   = ST_ALIVE;
          hp_d      = HP_FULL;
          respawn_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_ALIVE;
        hp_d    = HP_FULL;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_ALIVE;
      hp_q      <= HP_FULL;
      inv_q     <= 1'b0;
      dead_q    <= 1'b0;
      hit_q     <= 1'b0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      inv_q     <= (state_d == ST_INV);
      dead_q    <= (state_d == ST_DEAD);
      hit_q     <= hit_d;
      respawn_q <= respawn_d;
    end
  end

  assign OUT_HP  = hp_q;
  assign INV     = inv_q;
  assign DEAD    = dead_q;
  assign HIT     = hit_q;
  assign RESPAWN = respawn_q;

endmodule
